// File: rtl/odesa_pkg.sv
// Shared types and width helpers for the ODESA epoch sequencer and its sample player.
package odesa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
    GAP,
    DONE
  } state_t;

  // Every field keeps at least one bit, so degenerate sizes still elaborate.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_w(input int sample_num);
    return min1_clog2(sample_num);
  endfunction

  function automatic int time_cnt_w(input int sample_len);
    return min1_clog2(sample_len);
  endfunction

  function automatic int epoch_w(input int total_epochs);
    return min1_clog2(total_epochs + 1);
  endfunction

  function automatic int class_w(input int classes);
    return min1_clog2(classes);
  endfunction

  // Channel times occupy the low bits and the class index sits above them.
  function automatic int class_lsb(input int channels, input int time_w);
    return channels * time_w;
  endfunction

  function automatic int sample_w(input int channels, input int time_w, input int classes);
    return class_lsb(channels, time_w) + class_w(classes);
  endfunction

endpackage

// File: rtl/odesa_sample_player.sv
// Replays one latched sample: walks t across the window, fires channel spikes on time match
// and presents the one-hot class label while the sample plays.
module odesa_sample_player
  import odesa_pkg::*;
#(
  parameter int p_channels   = 4,
  parameter int p_classes    = 3,
  parameter int p_time_w     = 8,
  parameter int p_sample_len = 80
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [sample_w(p_channels, p_time_w, p_classes)-1:0]   sample,
  input  logic                                                   load,
  input  logic                                                   run,
  input  logic                                                   hold,
  input  logic                                                   label_en,
  output logic [p_channels-1:0]                                  events,
  output logic [p_classes-1:0]                                   label,
  output logic                                                   last
);

  localparam int SW      = sample_w(p_channels, p_time_w, p_classes);
  localparam int CLS_LSB = class_lsb(p_channels, p_time_w);
  localparam int CLS_W   = class_w(p_classes);
  localparam int TCW     = time_cnt_w(p_sample_len);
  localparam logic [TCW-1:0] T_LAST = TCW'(p_sample_len - 1);

  logic [CLS_LSB-1:0] times;
  logic [TCW-1:0]     t;
  logic [TCW-1:0]     t_next;

  assign t_next = t + TCW'(1);
  assign last   = (t == T_LAST);

  // Times beyond the window never match because t stays below p_sample_len.
  function automatic logic [p_channels-1:0] spikes(input logic [CLS_LSB-1:0] tv,
                                                   input logic [TCW-1:0] tt);
    logic [p_channels-1:0] v;
    v = '0;
    for (int c = 0; c < p_channels; c++) begin
      v[c] = (32'(tv[c*p_time_w +: p_time_w]) == 32'(tt));
    end
    return v;
  endfunction

  function automatic logic [p_classes-1:0] decode(input logic [SW-1:0] s);
    logic [p_classes-1:0] v;
    logic [CLS_W-1:0]     cls;
    cls = s[CLS_LSB +: CLS_W];
    v   = '0;
    for (int k = 0; k < p_classes; k++) begin
      v[k] = (32'(cls) == 32'(k));
    end
    return v;
  endfunction

  // Spikes are computed for the t that the next cycle will show, keeping outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      times  <= '0;
      t      <= '0;
      events <= '0;
      label  <= '0;
    end else if (load) begin
      times  <= sample[CLS_LSB-1:0];
      t      <= '0;
      events <= spikes(sample[CLS_LSB-1:0], '0);
      label  <= label_en ? decode(sample) : '0;
    end else if (run) begin
      if (last) begin
        events <= '0;
        label  <= '0;
      end else begin
        t      <= t_next;
        events <= spikes(times, t_next);
      end
    end else if (hold) begin
      events <= '0;
    end else begin
      events <= '0;
      label  <= '0;
    end
  end

endmodule

// File: rtl/odesa_epoch_sequencer.sv
// Replays a stored labelled dataset for training and evaluation epochs, then hands
// the L1 event bus over to live events.
module odesa_epoch_sequencer
  import odesa_pkg::*;
#(
  parameter int p_channels      = 4,
  parameter int p_classes       = 3,
  parameter int p_time_w        = 8,
  parameter int p_sample_num    = 75,
  parameter int p_sample_len    = 80,
  parameter int p_pattern_delay = 5000,
  parameter int p_epochs        = 350,
  parameter int p_eval_epochs   = 1
) (
  input  logic                                                 i_clk,
  input  logic                                                 i_rst,
  input  logic                                                 i_start,
  input  logic                                                 i_hold,
  output logic [addr_w(p_sample_num)-1:0]                      o_addr,
  input  logic [sample_w(p_channels, p_time_w, p_classes)-1:0] i_sample,
  input  logic [p_channels-1:0]                                i_event,
  output logic [p_channels-1:0]                                o_events,
  output logic [p_classes-1:0]                                 o_label,
  output logic                                                 o_training,
  output logic                                                 o_end_of_epochs,
  output logic [epoch_w(p_epochs + p_eval_epochs)-1:0]         o_epoch
);

  localparam int TOTAL = p_epochs + p_eval_epochs;
  localparam int AW    = addr_w(p_sample_num);
  localparam int EW    = epoch_w(TOTAL);
  localparam int GW    = min1_clog2(p_pattern_delay);
  localparam logic           NO_GAP      = (p_pattern_delay == 0);
  localparam logic [AW-1:0]  ADDR_LAST   = AW'(p_sample_num - 1);
  localparam logic [EW-1:0]  EPOCH_LAST  = EW'((TOTAL > 0) ? TOTAL - 1 : 0);
  localparam logic [EW-1:0]  EPOCH_TRAIN = EW'(p_epochs);
  localparam logic [GW-1:0]  GAP_LAST    = GW'((p_pattern_delay > 0) ? p_pattern_delay - 1 : 0);

  state_t                state;
  logic [AW-1:0]         addr;
  logic [EW-1:0]         epoch;
  logic [EW-1:0]         epoch_next;
  logic [GW-1:0]         gap;
  logic                  training;
  logic                  active;
  logic                  stall;
  logic                  load;
  logic                  run;
  logic                  play_last;
  logic                  sample_end;
  logic [p_channels-1:0] replay_events;
  logic [p_classes-1:0]  replay_label;

  assign active     = (state == FETCH) || (state == PLAY) || (state == GAP);
  assign stall      = i_hold && active;
  assign load       = (state == FETCH) && !i_hold;
  assign run        = (state == PLAY) && !i_hold;
  assign epoch_next = epoch + EW'(1);
  // A zero-length gap lets the last PLAY cycle close the sample directly.
  assign sample_end = (run && play_last && NO_GAP) ||
                      ((state == GAP) && !i_hold && (gap == GAP_LAST));

  odesa_sample_player #(
    .p_channels  (p_channels),
    .p_classes   (p_classes),
    .p_time_w    (p_time_w),
    .p_sample_len(p_sample_len)
  ) u_player (
    .clk     (i_clk),
    .rst     (i_rst),
    .sample  (i_sample),
    .load    (load),
    .run     (run),
    .hold    (stall),
    .label_en(training),
    .events  (replay_events),
    .label   (replay_label),
    .last    (play_last)
  );

  // Sample and epoch bookkeeping happens at the end of each gap; training is decided per epoch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      addr     <= '0;
      gap      <= '0;
      epoch    <= '0;
      training <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            if (TOTAL == 0) begin
              state <= DONE;
            end else begin
              state    <= FETCH;
              training <= (EPOCH_TRAIN != '0);
            end
          end
        end
        FETCH: begin
          if (!i_hold) state <= PLAY;
        end
        PLAY: begin
          if (run && play_last && !NO_GAP) begin
            state <= GAP;
            gap   <= '0;
          end
        end
        GAP: begin
          if (!i_hold && (gap != GAP_LAST)) gap <= gap + GW'(1);
        end
        default: ;
      endcase

      if (sample_end) begin
        if (addr == ADDR_LAST) begin
          addr  <= '0;
          epoch <= epoch_next;
          if (epoch == EPOCH_LAST) begin
            state    <= DONE;
            training <= 1'b0;
          end else begin
            state    <= FETCH;
            training <= (epoch_next < EPOCH_TRAIN);
          end
        end else begin
          addr  <= addr + AW'(1);
          state <= FETCH;
        end
      end
    end
  end

  assign o_addr          = addr;
  assign o_epoch         = epoch;
  assign o_training      = training;
  assign o_label         = replay_label;
  assign o_end_of_epochs = (state == DONE);
  // Live events bypass the registers once the dataset has been consumed.
  assign o_events        = (state == DONE) ? i_event : replay_events;

endmodule

// File: tb/tb_odesa_epoch_sequencer.sv
// Self-checking bench: a position-based model of the replay schedule predicts every output each cycle.
module tb_odesa_epoch_sequencer;

  localparam int CH     = 4;
  localparam int CL     = 3;
  localparam int TW     = 4;
  localparam int SN     = 2;
  localparam int SL     = 8;
  localparam int PD     = 3;
  localparam int EP     = 1;
  localparam int EV     = 1;
  localparam int PER    = 1 + SL + PD;
  localparam int TOTAL  = EP + EV;
  localparam int DONE_P = PER * SN * TOTAL;
  localparam int SW     = CH * TW + 2;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          hold  = 1'b0;
  logic [CH-1:0] ev    = '0;
  logic [0:0]    addr;
  logic [SW-1:0] sample;
  logic [CH-1:0] events;
  logic [CL-1:0] label;
  logic          training;
  logic          eoe;
  logic [1:0]    epoch;

  logic [SW-1:0] mem [SN];

  int checks = 0;
  int errors = 0;

  // Model state: position along the whole replay schedule, advanced by every non-held edge.
  bit active;
  int pos;
  bit held;

  assign sample = mem[addr];

  always #5 clk = ~clk;

  odesa_epoch_sequencer #(
    .p_channels     (CH),
    .p_classes      (CL),
    .p_time_w       (TW),
    .p_sample_num   (SN),
    .p_sample_len   (SL),
    .p_pattern_delay(PD),
    .p_epochs       (EP),
    .p_eval_epochs  (EV)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_hold         (hold),
    .o_addr         (addr),
    .i_sample       (sample),
    .i_event        (ev),
    .o_events       (events),
    .o_label        (label),
    .o_training     (training),
    .o_end_of_epochs(eoe),
    .o_epoch        (epoch)
  );

  always @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      pos    <= 0;
      held   <= 1'b0;
    end else if (!active) begin
      if (start) begin
        active <= 1'b1;
        pos    <= 0;
        held   <= 1'b0;
      end
    end else if (pos < DONE_P) begin
      if (hold) begin
        held <= 1'b1;
      end else begin
        held <= 1'b0;
        pos  <= pos + 1;
      end
    end
  end

  function automatic int time_of(input int s, input int c);
    logic [SW-1:0] w;
    w = mem[s];
    return int'(w[c*TW +: TW]);
  endfunction

  function automatic int class_of(input int s);
    logic [SW-1:0] w;
    w = mem[s];
    return int'(w[CH*TW +: 2]);
  endfunction

  function automatic logic [CH-1:0] exp_events();
    logic [CH-1:0] v;
    int r;
    int s;
    v = '0;
    if (!active) return v;
    if (pos == DONE_P) return ev;
    if (held) return v;
    r = pos % PER;
    if (r < 1 || r > SL) return v;
    s = (pos / PER) % SN;
    for (int c = 0; c < CH; c++) v[c] = (time_of(s, c) == r - 1);
    return v;
  endfunction

  function automatic logic [CL-1:0] exp_label();
    logic [CL-1:0] v;
    int r;
    int cls;
    v = '0;
    if (!active || pos >= DONE_P) return v;
    r = pos % PER;
    if (r < 1 || r > SL) return v;
    if (pos / (PER * SN) >= EP) return v;
    cls = class_of((pos / PER) % SN);
    if (cls < CL) v[cls] = 1'b1;
    return v;
  endfunction

  function automatic int exp_training();
    return (active && pos < DONE_P && (pos / (PER * SN)) < EP) ? 1 : 0;
  endfunction

  function automatic int exp_epoch();
    return active ? pos / (PER * SN) : 0;
  endfunction

  function automatic int exp_addr();
    return active ? (pos / PER) % SN : 0;
  endfunction

  function automatic int exp_end();
    return (active && pos == DONE_P) ? 1 : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic h, input logic [CH-1:0] e);
    start = s;
    hold  = h;
    ev    = e;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_events"}, 32'(events), 32'(0));
    checkOutput({tag, "_label"}, 32'(label), 32'(0));
    checkOutput({tag, "_training"}, 32'(training), 32'(0));
    checkOutput({tag, "_end"}, 32'(eoe), 32'(0));
    checkOutput({tag, "_epoch"}, 32'(epoch), 32'(0));
    checkOutput({tag, "_addr"}, 32'(addr), 32'(0));
  endtask

  always @(posedge clk) begin
    #2;
    checkOutput("model_events", 32'(events), 32'(exp_events()));
    checkOutput("model_label", 32'(label), 32'(exp_label()));
    checkOutput("model_training", 32'(training), 32'(exp_training()));
    checkOutput("model_epoch", 32'(epoch), 32'(exp_epoch()));
    checkOutput("model_addr", 32'(addr), 32'(exp_addr()));
    checkOutput("model_end", 32'(eoe), 32'(exp_end()));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lab_cnt;
    bit ch3_seen;
    int tail;

    // sample0 times {0,3,3,9} class 2; sample1 times {1,15,7,2} class 0
    mem[0] = {2'd2, 4'd9, 4'd3, 4'd3, 4'd0};
    mem[1] = {2'd0, 4'd2, 4'd7, 4'd15, 4'd1};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkIdleZero("reset");

    $display("[TB] directed replay, period and eval epoch");
    lab_cnt  = 0;
    ch3_seen = 1'b0;
    applyStimulus(1'b1, 1'b0, '0);
    for (int c = 0; c <= 48; c++) begin
      @(negedge clk);
      if (c == 0) applyStimulus(1'b0, 1'b0, '0);
      if (c < 12) begin
        if (label == 3'b100) lab_cnt++;
        if (events[3]) ch3_seen = 1'b1;
      end
      case (c)
        0: begin
          checkOutput("fetch_addr", 32'(addr), 32'(0));
          checkOutput("fetch_training", 32'(training), 32'(1));
        end
        1: begin
          checkOutput("t0_spike", 32'(events), 32'(4'b0001));
          checkOutput("t0_label", 32'(label), 32'(3'b100));
        end
        2:  checkOutput("t1_quiet", 32'(events), 32'(0));
        4:  checkOutput("t3_dual_spike", 32'(events), 32'(4'b0110));
        11: begin
          checkOutput("label_cycles", 32'(lab_cnt), 32'(8));
          checkOutput("ch3_silent", 32'(ch3_seen), 32'(0));
          checkOutput("gap_addr", 32'(addr), 32'(0));
        end
        12: checkOutput("sample1_fetch_addr", 32'(addr), 32'(1));
        24: begin
          checkOutput("epoch1_count", 32'(epoch), 32'(1));
          checkOutput("eval_training", 32'(training), 32'(0));
        end
        25: begin
          checkOutput("eval_t0_spike", 32'(events), 32'(4'b0001));
          checkOutput("eval_label", 32'(label), 32'(0));
        end
        28: checkOutput("eval_t3_spike", 32'(events), 32'(4'b0110));
        47: checkOutput("pre_done_end", 32'(eoe), 32'(0));
        48: begin
          checkOutput("done_end", 32'(eoe), 32'(1));
          checkOutput("done_epoch", 32'(epoch), 32'(2));
        end
        default: ;
      endcase
    end
    applyStimulus(1'b0, 1'b0, 4'b1010);
    #1;
    checkOutput("done_passthru", 32'(events), 32'(4'b1010));
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'b0101);
    #1;
    checkOutput("done_passthru2", 32'(events), 32'(4'b0101));
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("done_ignores_start", 32'(eoe), 32'(1));
    checkOutput("done_epoch_stable", 32'(epoch), 32'(2));

    $display("[TB] directed hold and mid-gap reset");
    doReset();
    checkIdleZero("reset2");
    applyStimulus(1'b1, 1'b0, '0);
    for (int c = 0; c <= 27; c++) begin
      @(negedge clk);
      if (c == 0) applyStimulus(1'b0, 1'b0, '0);
      case (c)
        3:  hold = 1'b1;
        8: begin
          checkOutput("hold_frozen", 32'(events), 32'(0));
          hold = 1'b0;
        end
        9:  checkOutput("hold_release_spike", 32'(events), 32'(4'b0110));
        16: checkOutput("hold_gap_addr", 32'(addr), 32'(0));
        17: checkOutput("hold_period_addr", 32'(addr), 32'(1));
        27: rst = 1'b1;
        default: ;
      endcase
    end
    @(negedge clk);
    checkIdleZero("gap_reset");
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, '0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("restart_addr", 32'(addr), 32'(0));
    @(negedge clk);
    checkOutput("restart_t0_spike", 32'(events), 32'(4'b0001));
    checkOutput("restart_label", 32'(label), 32'(3'b100));

    $display("[TB] randomized runs");
    for (int run = 0; run < 6; run++) begin
      doReset();
      for (int s = 0; s < SN; s++) begin
        logic [SW-1:0] w;
        w = '0;
        for (int c = 0; c < CH; c++) w[c*TW +: TW] = 4'($urandom_range(0, 15));
        w[CH*TW +: 2] = 2'($urandom_range(0, 3));
        mem[s] = w;
      end
      applyStimulus(1'b1, 1'b0, '0);
      tail = -1;
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        if (eoe && tail < 0) tail = 8;
        if (tail == 0) break;
        if (tail > 0) tail--;
        applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0), 4'($urandom));
      end
      checkOutput("random_done_reached", 32'(eoe), 32'(1));
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
